// File: rtl/regmux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regmux4_rr_arbiter
// Description : Round-robin arbiter that owns the select of a 4:1 register
//               mux shared by four requesters (A..D) and offers the selected
//               data to one consumer over a valid/ready handshake. Each grant
//               tenure is bounded by MAX_HOLD accepted transfers (0 = no
//               limit). Optional macro REGMUX_ARB_LOCK_EN adds a Lock input
//               that suppresses the MAX_HOLD release while asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module regmux4_rr_arbiter #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int BUS_WIDTH       = 2,    // only 2 is supported (four inputs)
    parameter int MAX_HOLD        = 4     // 0..65535, 0 = unlimited tenure
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [3:0]                 Request,
    input  logic [INPUT_BIT_WIDTH-1:0] InputA,
    input  logic [INPUT_BIT_WIDTH-1:0] InputB,
    input  logic [INPUT_BIT_WIDTH-1:0] InputC,
    input  logic [INPUT_BIT_WIDTH-1:0] InputD,
    input  logic                       Ready,
`ifdef REGMUX_ARB_LOCK_EN
    input  logic                       Lock,
`endif
    output logic [INPUT_BIT_WIDTH-1:0] Output,
    output logic                       Valid,
    output logic [3:0]                 Grant,
    output logic [BUS_WIDTH-1:0]       Select,
    output logic                       Busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Hold count value at which the next accepted transfer ends the tenure.
    localparam logic [15:0] HOLD_LAST    = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);
    localparam logic        HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [15:0] HOLD_SAT     = 16'hFFFF;

    state_t               state;
    logic [3:0]           grant;
    logic [BUS_WIDTH-1:0] select;
    logic [1:0]           pointer;
    logic [15:0]          hold_count;

    logic                       has_grant;
    logic                       valid;
    logic                       transfer;
    logic                       lock_active;
    logic                       limit_hit;
    logic                       release_now;
    logic [1:0]                 release_ptr;
    logic [1:0]                 pick_ptr;
    logic [1:0]                 pick_idx;
    logic [INPUT_BIT_WIDTH-1:0] data_out;

    // First requesting index found when scanning ptr, ptr+1, ... modulo 4.
    // The scan runs from the farthest offset down so the nearest one wins.
    function automatic logic [1:0] pick_index(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] res;
        res = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

`ifdef REGMUX_ARB_LOCK_EN
    // Lock only matters during a tenure; IDLE never looks at the hold limit.
    assign lock_active = Lock;
`else
    assign lock_active = 1'b0;
`endif

    assign has_grant   = |grant;
    assign valid       = has_grant & Request[select];
    assign transfer    = valid & Ready;
    assign limit_hit   = HOLD_LIMITED & transfer & (hold_count == HOLD_LAST) & ~lock_active;
    assign release_now = (state == GRANT) & (~Request[select] | limit_hit);

    // On release the current owner drops to lowest priority.
    assign release_ptr = select + 2'd1;
    assign pick_ptr    = (state == GRANT) ? release_ptr : pointer;
    assign pick_idx    = pick_index(Request, pick_ptr);

    // Data mux: selected input while a grant is held, zero otherwise.
    always_comb begin
        data_out = '0;
        if (has_grant) begin
            case (select)
                2'd0:    data_out = InputA;
                2'd1:    data_out = InputB;
                2'd2:    data_out = InputC;
                default: data_out = InputD;
            endcase
        end
    end

    // Arbitration state machine: grant, handover, tenure counting.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            grant      <= 4'b0000;
            select     <= '0;
            pointer    <= 2'd0;
            hold_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|Request) begin
                        state      <= GRANT;
                        grant      <= 4'b0001 << pick_idx;
                        select     <= pick_idx;
                        hold_count <= 16'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        pointer    <= release_ptr;
                        hold_count <= 16'd0;
                        if (|Request) begin
                            // Back-to-back handover, possibly to the same owner.
                            grant  <= 4'b0001 << pick_idx;
                            select <= pick_idx;
                        end else begin
                            // Select keeps its last value while idle.
                            state  <= IDLE;
                            grant  <= 4'b0000;
                        end
                    end else if (transfer && (hold_count != HOLD_SAT)) begin
                        hold_count <= hold_count + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                end
            endcase
        end
    end

    assign Output = data_out;
    assign Valid  = valid;
    assign Grant  = grant;
    assign Select = select;
    assign Busy   = (state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_regmux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regmux4_rr_arbiter
// Description : Directed self-checking bench for regmux4_rr_arbiter
//               (MAX_HOLD = 4). Lock scenario built when REGMUX_ARB_LOCK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regmux4_rr_arbiter;

    logic       Clock;
    logic       Reset;
    logic [3:0] Request;
    logic [7:0] InputA, InputB, InputC, InputD;
    logic       Ready;
`ifdef REGMUX_ARB_LOCK_EN
    logic       Lock;
`endif
    logic [7:0] Output;
    logic       Valid;
    logic [3:0] Grant;
    logic [1:0] Select;
    logic       Busy;

    int n_cmp = 0;
    int n_err = 0;

    regmux4_rr_arbiter #(
        .INPUT_BIT_WIDTH (8),
        .BUS_WIDTH       (2),
        .MAX_HOLD        (4)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Request (Request),
        .InputA  (InputA),
        .InputB  (InputB),
        .InputC  (InputC),
        .InputD  (InputD),
        .Ready   (Ready),
`ifdef REGMUX_ARB_LOCK_EN
        .Lock    (Lock),
`endif
        .Output  (Output),
        .Valid   (Valid),
        .Grant   (Grant),
        .Select  (Select),
        .Busy    (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        Request = 4'b0000;
        Ready   = 1'b0;
        tick();
        tick();
        Reset   = 1'b0;
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        Request = 4'b1111;
        Ready   = 1'b1;
        InputA  = 8'd42;
        InputB  = 8'd15;
        InputC  = 8'd2;
        InputD  = 8'd0;
        tick();
        tick();
        n_cmp++;
        if ({Grant, Select, Valid, Busy, Output} !== {4'b0000, 2'd0, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state: got G=%b S=%0d V=%b B=%b O=%0d, want G=0000 S=0 V=0 B=0 O=0",
                     Grant, Select, Valid, Busy, Output);
        end
        Reset = 1'b0;
        tick();
        n_cmp++;
        if ({Grant, Select, Valid, Busy, Output} !== {4'b0001, 2'd0, 1'b1, 1'b1, 8'd42}) begin
            n_err++;
            $display("FAIL reset_first_grant: got G=%b S=%0d V=%b B=%b O=%0d, want G=0001 S=0 V=1 B=1 O=42",
                     Grant, Select, Valid, Busy, Output);
        end
    endtask

    task automatic test_single();
        do_reset();
        Request = 4'b0010;
        Ready   = 1'b1;
        tick();
        n_cmp++;
        if ({Grant, Select, Valid, Busy, Output} !== {4'b0010, 2'd1, 1'b1, 1'b1, 8'd15}) begin
            n_err++;
            $display("FAIL single_grant: got G=%b S=%0d V=%b B=%b O=%0d, want G=0010 S=1 V=1 B=1 O=15",
                     Grant, Select, Valid, Busy, Output);
        end
        // Two full tenures: B re-granted at the release edge, no bubble.
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if ({Grant, Busy, Valid, Output} !== {4'b0010, 1'b1, 1'b1, 8'd15}) begin
                n_err++;
                $display("FAIL single_regrant[%0d]: got G=%b B=%b V=%b O=%0d, want G=0010 B=1 V=1 O=15",
                         k, Grant, Busy, Valid, Output);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data [4];
        int         idx;
        exp_data[0] = 8'd42;
        exp_data[1] = 8'd15;
        exp_data[2] = 8'd2;
        exp_data[3] = 8'd0;
        do_reset();
        Request = 4'b1111;
        Ready   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            idx = (k / 4) % 4;
            n_cmp++;
            if ({Grant, Select, Valid, Output} !== {4'(1 << idx), 2'(idx), 1'b1, exp_data[idx]}) begin
                n_err++;
                $display("FAIL round_robin[%0d]: got G=%b S=%0d V=%b O=%0d, want G=%b S=%0d V=1 O=%0d",
                         k, Grant, Select, Valid, Output, 4'(1 << idx), idx, exp_data[idx]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        Request = 4'b0010;
        Ready   = 1'b0;
        tick();
        Request = 4'b0011;  // A waits; it should only win after B's 4th transfer
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({Grant, Select, Valid, Output} !== {4'b0010, 2'd1, 1'b1, 8'd15}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got G=%b S=%0d V=%b O=%0d, want G=0010 S=1 V=1 O=15",
                         k, Grant, Select, Valid, Output);
            end
        end
        Ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if (Grant !== 4'b0010) begin
                n_err++;
                $display("FAIL stall_resume[%0d]: got G=%b, want G=0010", k, Grant);
            end
        end
        tick();
        n_cmp++;
        if ({Grant, Select, Output} !== {4'b0001, 2'd0, 8'd42}) begin
            n_err++;
            $display("FAIL stall_release: got G=%b S=%0d O=%0d, want G=0001 S=0 O=42",
                     Grant, Select, Output);
        end
    endtask

    task automatic test_request_drop();
        do_reset();
        Request = 4'b0101;
        Ready   = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if (Grant !== 4'b0001) begin
            n_err++;
            $display("FAIL drop_before: got G=%b, want G=0001", Grant);
        end
        Request = 4'b0100;
        #1;
        n_cmp++;
        if (Valid !== 1'b0) begin
            n_err++;
            $display("FAIL drop_valid: got V=%b, want V=0", Valid);
        end
        tick();
        n_cmp++;
        if ({Grant, Select, Valid, Output} !== {4'b0100, 2'd2, 1'b1, 8'd2}) begin
            n_err++;
            $display("FAIL drop_handover: got G=%b S=%0d V=%b O=%0d, want G=0100 S=2 V=1 O=2",
                     Grant, Select, Valid, Output);
        end
        // All requests gone: idle, Select retained, Output zero.
        Request = 4'b0000;
        tick();
        n_cmp++;
        if ({Grant, Select, Valid, Busy, Output} !== {4'b0000, 2'd2, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL drop_idle: got G=%b S=%0d V=%b B=%b O=%0d, want G=0000 S=2 V=0 B=0 O=0",
                     Grant, Select, Valid, Busy, Output);
        end
        // Pointer now 3 after C released, so D wins from IDLE.
        Request = 4'b1111;
        tick();
        n_cmp++;
        if ({Grant, Select, Busy} !== {4'b1000, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL idle_pointer: got G=%b S=%0d B=%b, want G=1000 S=3 B=1",
                     Grant, Select, Busy);
        end
    endtask

`ifdef REGMUX_ARB_LOCK_EN
    task automatic test_lock_reset();
        do_reset();
        Lock    = 1'b1;
        Request = 4'b0011;
        Ready   = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if ({Grant, Valid} !== {4'b0001, 1'b1}) begin
                n_err++;
                $display("FAIL lock_hold[%0d]: got G=%b V=%b, want G=0001 V=1", k, Grant, Valid);
            end
        end
        Reset = 1'b1;
        tick();
        n_cmp++;
        if ({Grant, Busy} !== {4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL lock_reset: got G=%b B=%b, want G=0000 B=0", Grant, Busy);
        end
        Reset = 1'b0;
        Lock  = 1'b0;
        tick();
        n_cmp++;
        if (Grant !== 4'b0001) begin
            n_err++;
            $display("FAIL lock_regrant: got G=%b, want G=0001", Grant);
        end
    endtask
`endif

    initial begin
        Reset   = 1'b1;
        Request = 4'b0000;
        Ready   = 1'b0;
        InputA  = 8'd0;
        InputB  = 8'd0;
        InputC  = 8'd0;
        InputD  = 8'd0;
`ifdef REGMUX_ARB_LOCK_EN
        Lock    = 1'b0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_request_drop();
`ifdef REGMUX_ARB_LOCK_EN
        test_lock_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
